// File: rtl/triangle_setup.sv
`default_nettype none
// ============================================================================
// triangle_setup
// Triangle setup: edge coefficients, 2x area and clipped bbox on one shared
// multiplier. Define TRI_SETUP_STATS_EN to add accept/discard counters.
// Revision: 1.0
// ============================================================================
module triangle_setup #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tri_valid,
  output logic               o_busy,
  input  logic signed [15:0] i_x0, i_y0, i_x1, i_y1, i_x2, i_y2,
  input  logic        [7:0]  i_z0, i_z1, i_z2,
  input  logic        [31:0] i_u0, i_u1, i_u2, i_v0, i_v1, i_v2,
  output logic               o_setup_valid,
  input  logic               i_raster_ready,
  output logic signed [16:0] o_a0, o_a1, o_a2,
  output logic signed [16:0] o_b0, o_b1, o_b2,
  output logic signed [32:0] o_c0, o_c1, o_c2,
  output logic signed [34:0] o_area2,
  output logic        [15:0] o_xmin, o_xmax, o_ymin, o_ymax,
  output logic        [7:0]  o_z0, o_z1, o_z2,
`ifdef TRI_SETUP_STATS_EN
  output logic        [31:0] o_tri_in_cnt,
  output logic        [31:0] o_tri_offscreen_cnt,
`endif
  output logic        [31:0] o_u0, o_u1, o_u2, o_v0, o_v1, o_v2
);

  localparam logic signed [15:0] c_X_LAST = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] c_Y_LAST = 16'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CLIP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        [2:0]  r_k;
  logic signed [15:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;

  logic signed [15:0] w_mul_a, w_mul_b;
  logic signed [31:0] w_prod;
  logic signed [32:0] w_prod_ext;
  logic signed [15:0] w_xmin_raw, w_xmax_raw, w_ymin_raw, w_ymax_raw;
  logic               w_offscreen;
  logic               w_accept;

  function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign w_accept = (r_state == S_IDLE) && i_tri_valid && !o_busy;

  // Product order: even k is the positive term of C[k/2], odd k the negative.
  always_comb begin
    w_mul_a = r_x0;
    w_mul_b = r_y1;
    case (r_k)
      3'd0:    begin w_mul_a = r_x0; w_mul_b = r_y1; end
      3'd1:    begin w_mul_a = r_x1; w_mul_b = r_y0; end
      3'd2:    begin w_mul_a = r_x1; w_mul_b = r_y2; end
      3'd3:    begin w_mul_a = r_x2; w_mul_b = r_y1; end
      3'd4:    begin w_mul_a = r_x2; w_mul_b = r_y0; end
      3'd5:    begin w_mul_a = r_x0; w_mul_b = r_y2; end
      default: begin w_mul_a = r_x0; w_mul_b = r_y1; end
    endcase
  end

  assign w_prod     = w_mul_a * w_mul_b;
  assign w_prod_ext = {w_prod[31], w_prod};

  assign w_xmin_raw = min3(r_x0, r_x1, r_x2);
  assign w_xmax_raw = max3(r_x0, r_x1, r_x2);
  assign w_ymin_raw = min3(r_y0, r_y1, r_y2);
  assign w_ymax_raw = max3(r_y0, r_y1, r_y2);

  assign w_offscreen = w_xmax_raw[15] || (w_xmin_raw > c_X_LAST) ||
                       w_ymax_raw[15] || (w_ymin_raw > c_Y_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MUL;
      S_MUL:   if (r_k == 3'd5) w_state_nxt = S_CLIP;
      S_CLIP:  w_state_nxt = w_offscreen ? S_IDLE : S_OUT;
      S_OUT:   if (i_raster_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy        <= 1'b0;
      o_setup_valid <= 1'b0;
    end else begin
      o_busy        <= (w_state_nxt != S_IDLE);
      o_setup_valid <= (w_state_nxt == S_OUT);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k     <= 3'd0;
      r_x0    <= '0; r_y0 <= '0; r_x1 <= '0;
      r_y1    <= '0; r_x2 <= '0; r_y2 <= '0;
      o_a0    <= '0; o_a1 <= '0; o_a2 <= '0;
      o_b0    <= '0; o_b1 <= '0; o_b2 <= '0;
      o_c0    <= '0; o_c1 <= '0; o_c2 <= '0;
      o_area2 <= '0;
      o_xmin  <= '0; o_xmax <= '0; o_ymin <= '0; o_ymax <= '0;
      o_z0    <= '0; o_z1 <= '0; o_z2 <= '0;
      o_u0    <= '0; o_u1 <= '0; o_u2 <= '0;
      o_v0    <= '0; o_v1 <= '0; o_v2 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_k  <= 3'd0;
            r_x0 <= i_x0; r_y0 <= i_y0; r_x1 <= i_x1;
            r_y1 <= i_y1; r_x2 <= i_x2; r_y2 <= i_y2;
            o_c0 <= '0; o_c1 <= '0; o_c2 <= '0;
            o_z0 <= i_z0; o_z1 <= i_z1; o_z2 <= i_z2;
            o_u0 <= i_u0; o_u1 <= i_u1; o_u2 <= i_u2;
            o_v0 <= i_v0; o_v1 <= i_v1; o_v2 <= i_v2;
          end
        end
        S_MUL: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd0) begin
            o_a0 <= {r_y0[15], r_y0} - {r_y1[15], r_y1};
            o_a1 <= {r_y1[15], r_y1} - {r_y2[15], r_y2};
            o_a2 <= {r_y2[15], r_y2} - {r_y0[15], r_y0};
            o_b0 <= {r_x1[15], r_x1} - {r_x0[15], r_x0};
            o_b1 <= {r_x2[15], r_x2} - {r_x1[15], r_x1};
            o_b2 <= {r_x0[15], r_x0} - {r_x2[15], r_x2};
          end
          case (r_k[2:1])
            2'd0:    o_c0 <= r_k[0] ? (o_c0 - w_prod_ext) : (o_c0 + w_prod_ext);
            2'd1:    o_c1 <= r_k[0] ? (o_c1 - w_prod_ext) : (o_c1 + w_prod_ext);
            2'd2:    o_c2 <= r_k[0] ? (o_c2 - w_prod_ext) : (o_c2 + w_prod_ext);
            default: ;
          endcase
        end
        S_CLIP: begin
          r_k     <= 3'd0;
          o_area2 <= {{2{o_c0[32]}}, o_c0} + {{2{o_c1[32]}}, o_c1} +
                     {{2{o_c2[32]}}, o_c2};
          // Off-screen extremes cannot reach the clamped side, so one clamp each.
          o_xmin  <= w_xmin_raw[15] ? 16'd0 : w_xmin_raw;
          o_ymin  <= w_ymin_raw[15] ? 16'd0 : w_ymin_raw;
          o_xmax  <= (w_xmax_raw > c_X_LAST) ? c_X_LAST : w_xmax_raw;
          o_ymax  <= (w_ymax_raw > c_Y_LAST) ? c_Y_LAST : w_ymax_raw;
        end
        default: ;
      endcase
    end
  end

`ifdef TRI_SETUP_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tri_in_cnt        <= 32'd0;
      o_tri_offscreen_cnt <= 32'd0;
    end else begin
      if (w_accept) o_tri_in_cnt <= o_tri_in_cnt + 32'd1;
      if ((r_state == S_CLIP) && w_offscreen)
        o_tri_offscreen_cnt <= o_tri_offscreen_cnt + 32'd1;
    end
  end
`else
`endif

endmodule
`default_nettype wire
